iob_fifo_sync_fwft: RTL and testbench

//  Synchronous first-word-fall-through FIFO with valid/ready on both sides and asymmetric widths.

---
 rtl/iob_fifo_sync_fwft.sv | 119 +++++++++++
 tb/tb_iob_fifo_sync_fwft.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo_sync_fwft.sv
// Synchronous first-word-fall-through FIFO, valid/ready on both sides, asymmetric widths.
// Define IOB_FIFO_SYNC_HWM_EN to add the hwm/hwm_clr high-water-mark ports.
module iob_fifo_sync_fwft #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 32,
    parameter int ADDR_W   = 4
) (
    input  logic                ap_clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W_DATA_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [R_DATA_W-1:0] out_data,
    input  logic [ADDR_W:0]     af_level,
    input  logic [ADDR_W:0]     ae_level,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDR_W:0]     level
`ifdef IOB_FIFO_SYNC_HWM_EN
    ,
    output logic [ADDR_W:0]     hwm,
    input  logic                hwm_clr
`endif
);

    localparam int MIN_W  = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int MAX_W  = (W_DATA_W < R_DATA_W) ? R_DATA_W : W_DATA_W;
    localparam int N      = MAX_W / MIN_W;
    localparam int W_INCR = (W_DATA_W > R_DATA_W) ? N : 1;
    localparam int R_INCR = (R_DATA_W > W_DATA_W) ? N : 1;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int LW     = ADDR_W + 1;

    logic [MIN_W-1:0]    mem [DEPTH];
    logic [ADDR_W-1:0]   wptr;
    logic [ADDR_W-1:0]   rptr;
    logic [ADDR_W:0]     mem_units;
    logic                rd_valid;
    logic [R_DATA_W-1:0] rd_data;

    logic            accept;
    logic            pop;
    logic            move;
    logic            fetch;
    logic [ADDR_W:0] level_nxt;
    logic [ADDR_W:0] units_nxt;

    assign in_ready     = level <= LW'(DEPTH - W_INCR);
    assign almost_full  = level >= af_level;
    assign almost_empty = level <= ae_level;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;
    // rd_data is the registered memory read; it advances into out_data
    // whenever the output stage is empty or being consumed.
    assign move   = rd_valid & (~out_valid | out_ready);
    assign fetch  = (mem_units >= LW'(R_INCR)) & (~rd_valid | move);

    // Level is bounded by DEPTH, so LW-bit modular arithmetic is exact.
    assign level_nxt = level
                     + (accept ? LW'(W_INCR) : '0)
                     - (pop    ? LW'(R_INCR) : '0);
    assign units_nxt = mem_units
                     + (accept ? LW'(W_INCR) : '0)
                     - (fetch  ? LW'(R_INCR) : '0);

    always_ff @(posedge ap_clk) begin
        if (accept && !rst) begin
            for (int i = 0; i < W_INCR; i++) begin
                mem[wptr + ADDR_W'(i)] <= in_data[i*MIN_W +: MIN_W];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            mem_units <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            level     <= level_nxt;
            mem_units <= units_nxt;
            if (accept) begin
                wptr <= wptr + ADDR_W'(W_INCR);
            end
            if (fetch) begin
                rptr <= rptr + ADDR_W'(R_INCR);
                for (int i = 0; i < R_INCR; i++) begin
                    rd_data[i*MIN_W +: MIN_W] <= mem[rptr + ADDR_W'(i)];
                end
            end
            rd_valid <= fetch | (rd_valid & ~move);
            if (move) begin
                out_data <= rd_data;
            end
            out_valid <= move | (out_valid & ~out_ready);
        end
    end

`ifdef IOB_FIFO_SYNC_HWM_EN
    always_ff @(posedge ap_clk) begin
        if (rst) begin
            hwm <= '0;
        end else if (hwm_clr) begin
            hwm <= level;
        end else if (level > hwm) begin
            hwm <= level;
        end
    end
`endif

endmodule

// File: tb/tb_iob_fifo_sync_fwft.sv
// Directed bench for iob_fifo_sync_fwft.
// Instances: 32->32, 8->32 and 32->8, all ADDR_W=4.
`timescale 1ns/1ps
module tb_iob_fifo_sync_fwft;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW:0] af_level;
    logic [AW:0] ae_level;
    int checks = 0;
    int errors = 0;

    logic        e_iv, e_ir, e_ov, e_or, e_af, e_ae;
    logic [31:0] e_id, e_od;
    logic [AW:0] e_lv;
    logic        n_iv, n_ir, n_ov, n_or, n_af, n_ae;
    logic [7:0]  n_id;
    logic [31:0] n_od;
    logic [AW:0] n_lv;
    logic        w_iv, w_ir, w_ov, w_or, w_af, w_ae;
    logic [31:0] w_id;
    logic [7:0]  w_od;
    logic [AW:0] w_lv;
`ifdef IOB_FIFO_SYNC_HWM_EN
    logic [AW:0] e_hwm, n_hwm, w_hwm;
    logic        e_hwm_clr;
    logic        x_hwm_clr = 1'b0;
`endif

    iob_fifo_sync_fwft #(.W_DATA_W(32), .R_DATA_W(32), .ADDR_W(AW)) u_eq (
        .ap_clk(clk), .rst(rst),
        .in_valid(e_iv), .in_ready(e_ir), .in_data(e_id),
        .out_valid(e_ov), .out_ready(e_or), .out_data(e_od),
        .af_level(af_level), .ae_level(ae_level),
        .almost_full(e_af), .almost_empty(e_ae), .level(e_lv)
`ifdef IOB_FIFO_SYNC_HWM_EN
        , .hwm(e_hwm), .hwm_clr(e_hwm_clr)
`endif
    );

    iob_fifo_sync_fwft #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(AW)) u_n2w (
        .ap_clk(clk), .rst(rst),
        .in_valid(n_iv), .in_ready(n_ir), .in_data(n_id),
        .out_valid(n_ov), .out_ready(n_or), .out_data(n_od),
        .af_level(af_level), .ae_level(ae_level),
        .almost_full(n_af), .almost_empty(n_ae), .level(n_lv)
`ifdef IOB_FIFO_SYNC_HWM_EN
        , .hwm(n_hwm), .hwm_clr(x_hwm_clr)
`endif
    );

    iob_fifo_sync_fwft #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(AW)) u_w2n (
        .ap_clk(clk), .rst(rst),
        .in_valid(w_iv), .in_ready(w_ir), .in_data(w_id),
        .out_valid(w_ov), .out_ready(w_or), .out_data(w_od),
        .af_level(af_level), .ae_level(ae_level),
        .almost_full(w_af), .almost_empty(w_ae), .level(w_lv)
`ifdef IOB_FIFO_SYNC_HWM_EN
        , .hwm(w_hwm), .hwm_clr(x_hwm_clr)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        e_iv = 0; e_or = 0; e_id = '0;
        n_iv = 0; n_or = 0; n_id = '0;
        w_iv = 0; w_or = 0; w_id = '0;
        af_level = 5'd12; ae_level = 5'd2;
`ifdef IOB_FIFO_SYNC_HWM_EN
        e_hwm_clr = 0;
`endif
        rst = 1;
        tick(); tick();
        checks++;
        if (e_lv !== 5'd0 || e_ov !== 1'b0 || e_ir !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got lv=%0d ov=%0b ir=%0b want 0 0 1",
                     e_lv, e_ov, e_ir);
        end
        checks++;
        if (e_ae !== 1'b1 || e_af !== 1'b0 || e_od !== 32'h0) begin
            errors++;
            $display("FAIL reset_flags: got ae=%0b af=%0b od=%0h want 1 0 0",
                     e_ae, e_af, e_od);
        end
        checks++;
        if (n_ov !== 1'b0 || w_ov !== 1'b0 || n_lv !== 5'd0 || w_lv !== 5'd0) begin
            errors++;
            $display("FAIL reset_asym: got n_ov=%0b w_ov=%0b n_lv=%0d w_lv=%0d want 0 0 0 0",
                     n_ov, w_ov, n_lv, w_lv);
        end
        rst = 0;
        tick();
    endtask

    task automatic drain_eq(input int first, input int last, input string tag);
        e_or = 1;
        for (int j = first; j <= last; j++) begin
            int g = 0;
            while (!e_ov && g < 20) begin
                tick();
                g++;
            end
            checks++;
            if (e_ov !== 1'b1 || e_od !== 32'(j)) begin
                errors++;
                $display("FAIL %s[%0d]: got v=%0b d=%0h want v=1 d=%0h",
                         tag, j, e_ov, e_od, j);
            end
            tick();
        end
        e_or = 0;
    endtask

    task automatic test_fill_drain();
        e_or = 0;
        for (int i = 0; i < 16; i++) begin
            e_iv = 1; e_id = 32'(i);
            tick();
        end
        checks++;
        if (e_ir !== 1'b0 || e_lv !== 5'd16) begin
            errors++;
            $display("FAIL full_state: got ir=%0b lv=%0d want 0 16", e_ir, e_lv);
        end
        e_id = 32'd99;
        tick(); tick();
        e_iv = 0;
        checks++;
        if (e_lv !== 5'd16 || e_ov !== 1'b1 || e_od !== 32'd0) begin
            errors++;
            $display("FAIL full_hold: got lv=%0d ov=%0b od=%0h want 16 1 0",
                     e_lv, e_ov, e_od);
        end
        drain_eq(0, 15, "drain");
        checks++;
        if (e_lv !== 5'd0 || e_ov !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got lv=%0d ov=%0b want 0 0", e_lv, e_ov);
        end
    endtask

    task automatic test_n2w();
        logic [7:0] b [3];
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            n_iv = 1; n_id = b[i];
            tick();
        end
        n_iv = 0;
        tick(); tick(); tick();
        checks++;
        if (n_ov !== 1'b0 || n_lv !== 5'd3) begin
            errors++;
            $display("FAIL n2w_partial: got ov=%0b lv=%0d want 0 3", n_ov, n_lv);
        end
        n_iv = 1; n_id = 8'h44;
        tick();
        n_iv = 0;
        checks++;
        if (n_ov !== 1'b0) begin
            errors++;
            $display("FAIL n2w_lat1: got ov=%0b want 0", n_ov);
        end
        tick();
        checks++;
        if (n_ov !== 1'b0) begin
            errors++;
            $display("FAIL n2w_lat2: got ov=%0b want 0", n_ov);
        end
        tick();
        checks++;
        if (n_ov !== 1'b1 || n_od !== 32'h44332211 || n_lv !== 5'd4) begin
            errors++;
            $display("FAIL n2w_word: got ov=%0b od=%0h lv=%0d want 1 44332211 4",
                     n_ov, n_od, n_lv);
        end
        n_or = 1;
        tick();
        n_or = 0;
        checks++;
        if (n_ov !== 1'b0 || n_lv !== 5'd0) begin
            errors++;
            $display("FAIL n2w_pop: got ov=%0b lv=%0d want 0 0", n_ov, n_lv);
        end
    endtask

    task automatic test_w2n();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
        w_iv = 1; w_id = 32'hA1B2C3D4;
        tick();
        w_iv = 0;
        tick(); tick();
        w_or = 1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (w_ov !== 1'b1 || w_od !== exp_b[k] || w_lv !== 5'(4 - k)) begin
                errors++;
                $display("FAIL w2n_slice[%0d]: got ov=%0b od=%0h lv=%0d want 1 %0h %0d",
                         k, w_ov, w_od, w_lv, exp_b[k], 4 - k);
            end
            tick();
        end
        w_or = 0;
        checks++;
        if (w_ov !== 1'b0 || w_lv !== 5'd0) begin
            errors++;
            $display("FAIL w2n_empty: got ov=%0b lv=%0d want 0 0", w_ov, w_lv);
        end
    endtask

    task automatic test_back_to_back();
        int nxt_in;
        int exp_out;
        logic took;
        e_or = 0;
        for (int i = 0; i < 16; i++) begin
            e_iv = 1; e_id = 32'(i);
            tick();
        end
        nxt_in = 16;
        exp_out = 0;
        e_or = 1;
        for (int c = 0; c < 100; c++) begin
            e_id = 32'(nxt_in);
            checks++;
            if (e_ov !== 1'b1 || e_od !== 32'(exp_out)) begin
                errors++;
                $display("FAIL b2b[%0d]: got v=%0b d=%0h want v=1 d=%0h",
                         c, e_ov, e_od, exp_out);
            end
            took = e_ir;
            tick();
            exp_out++;
            if (took) nxt_in++;
        end
        e_iv = 0;
        checks++;
        if (e_lv !== 5'd15) begin
            errors++;
            $display("FAIL b2b_level: got %0d want 15", e_lv);
        end
        drain_eq(exp_out, nxt_in - 1, "b2b_tail");
        checks++;
        if (e_lv !== 5'd0 || e_ov !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty: got lv=%0d ov=%0b want 0 0", e_lv, e_ov);
        end
    endtask

    task automatic test_almost();
        int g;
        e_or = 0;
        for (int i = 0; i < 12; i++) begin
            e_iv = 1; e_id = 32'(i);
            tick();
            if (i == 10) begin
                checks++;
                if (e_af !== 1'b0) begin
                    errors++;
                    $display("FAIL af_below: got %0b want 0 at level %0d", e_af, e_lv);
                end
            end
        end
        e_iv = 0;
        checks++;
        if (e_af !== 1'b1 || e_lv !== 5'd12) begin
            errors++;
            $display("FAIL af_hit: got af=%0b lv=%0d want 1 12", e_af, e_lv);
        end
        e_or = 1;
        for (int p = 1; p <= 10; p++) begin
            tick();
            if (p == 9) begin
                checks++;
                if (e_ae !== 1'b0 || e_lv !== 5'd3) begin
                    errors++;
                    $display("FAIL ae_above: got ae=%0b lv=%0d want 0 3", e_ae, e_lv);
                end
            end
        end
        checks++;
        if (e_ae !== 1'b1 || e_lv !== 5'd2) begin
            errors++;
            $display("FAIL ae_hit: got ae=%0b lv=%0d want 1 2", e_ae, e_lv);
        end
        g = 0;
        while (e_lv != 0 && g < 20) begin
            tick();
            g++;
        end
        e_or = 0;
        af_level = 5'd0;
        ae_level = 5'd0;
        #1;
        checks++;
        if (e_af !== 1'b1 || e_ae !== 1'b1 || e_lv !== 5'd0) begin
            errors++;
            $display("FAIL thr_zero: got af=%0b ae=%0b lv=%0d want 1 1 0",
                     e_af, e_ae, e_lv);
        end
        af_level = 5'd12;
        ae_level = 5'd2;
        #1;
        checks++;
        if (e_af !== 1'b0) begin
            errors++;
            $display("FAIL thr_restore: got af=%0b want 0", e_af);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        e_or = 0;
        for (int i = 0; i < 7; i++) begin
            e_iv = 1; e_id = 32'(100 + i);
            tick();
        end
        e_iv = 0;
        tick(); tick();
        checks++;
        if (e_lv !== 5'd7 || e_ov !== 1'b1) begin
            errors++;
            $display("FAIL mid_before: got lv=%0d ov=%0b want 7 1", e_lv, e_ov);
        end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (e_lv !== 5'd0 || e_ov !== 1'b0 || e_ir !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got lv=%0d ov=%0b ir=%0b want 0 0 1",
                     e_lv, e_ov, e_ir);
        end
`ifdef IOB_FIFO_SYNC_HWM_EN
        checks++;
        if (e_hwm !== 5'd0) begin
            errors++;
            $display("FAIL hwm_reset: got %0d want 0", e_hwm);
        end
`endif
        e_or = 1;
        tick(); tick(); tick();
        checks++;
        if (e_ov !== 1'b0 || e_lv !== 5'd0) begin
            errors++;
            $display("FAIL mid_no_ghost: got ov=%0b lv=%0d want 0 0", e_ov, e_lv);
        end
        e_or = 0;
        for (int i = 0; i < 9; i++) begin
            e_iv = 1; e_id = 32'(i);
            tick();
        end
        e_iv = 0;
        tick();
        drain_eq(0, 8, "refill");
        g = 0;
        while (e_lv != 0 && g < 20) begin
            tick();
            g++;
        end
`ifdef IOB_FIFO_SYNC_HWM_EN
        checks++;
        if (e_hwm !== 5'd9) begin
            errors++;
            $display("FAIL hwm_peak: got %0d want 9", e_hwm);
        end
        e_hwm_clr = 1;
        tick();
        e_hwm_clr = 0;
        checks++;
        if (e_hwm !== 5'd0) begin
            errors++;
            $display("FAIL hwm_clr: got %0d want 0", e_hwm);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_n2w();
        test_w2n();
        test_back_to_back();
        test_almost();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
